t_clkq_ring_meter: RTL
======================

T_CLKQ_RING_METER -- requirements
Module: t_clkq_ring_meter

Interface
REQ-001 SHALL have parameter N, default 16, meaning maximum number of token-ring DFF stages (N >= 2).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning lap-count width.
REQ-003 SHALL have parameter WIN_WIDTH, default 12, meaning measurement-window width in clock cycles.
REQ-004 SHALL have port clk  input  1  single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request for one measurement, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  cancels a measurement in progress.
REQ-008 SHALL have port chain_len  input  $clog2(N+1)  active ring length L, latched at start.
REQ-009 SHALL have port win_len  input  WIN_WIDTH  window length W in cycles, latched at start.
REQ-010 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on measurement completion.
REQ-012 SHALL have port lap_cnt  output  CNT_WIDTH  held result of the last completed measurement.
REQ-013 SHALL have port overflow  output  1  sticky flag: lap count saturated.
REQ-014 SHALL have port token_err  output  1  sticky flag: ring not one-hot during RUN.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-016 SHALL, in IDLE with start=1 and abort=0, latch L and W and move to LOAD; start in any other state SHALL be ignored.
REQ-017 SHALL clamp L: values below 2 become 2, values above N become N; W=0 SHALL be treated as 1.
REQ-018 SHALL spend exactly one cycle in LOAD: ring cleared with stage 0 = 1, window counter loaded with W, lap counter, overflow and token_err cleared; next state RUN.
REQ-019 SHALL shift the ring each RUN cycle: stage 0 takes stage L-1, stage i takes stage i-1 for 0 < i < L, stages >= L held at 0.
REQ-020 SHALL increment the lap counter on every RUN cycle in which stage L-1 = 1.
REQ-021 SHALL remain in RUN for exactly W cycles, then go to DONE, so lap_cnt = floor(W/L).
REQ-022 SHALL saturate the lap counter at 2^CNT_WIDTH-1 and set overflow when an increment is attempted at saturation.
REQ-023 SHALL set token_err when, in any RUN cycle, stages [L-1:0] do not contain exactly one 1.
REQ-024 SHALL update lap_cnt with the final count (including the last RUN cycle) on the RUN->DONE edge.
REQ-025 SHALL assert done for the single DONE cycle, then return to IDLE; start during DONE is ignored.
REQ-026 SHALL, on abort=1 in LOAD or RUN, return to IDLE on the next edge with no done pulse; lap_cnt SHALL keep its previous value.
REQ-027 SHALL give abort priority over start when both are high in IDLE (stay IDLE).
REQ-028 SHALL hold overflow and token_err until the next LOAD or reset.

Reset
REQ-029 SHALL, on rst_n=0 and regardless of clk, go to IDLE and clear ring, counters, lap_cnt, busy, done, overflow and token_err to 0.
REQ-030 SHALL, on reset during LOAD or RUN, abandon the measurement with no done pulse after release.

Verification
REQ-031 SHALL cover N=16, L=16, W=100, start at edge 0: busy cycles 1-101, done in cycle 102, lap_cnt=6.
REQ-032 SHALL cover L=3 with W=9 -> lap_cnt=3, and W=8 -> lap_cnt=2; start during busy produces no second measurement.
REQ-033 SHALL cover CNT_WIDTH=4, L=2, W=100: lap_cnt=15, overflow=1; the next start clears overflow.
REQ-034 SHALL cover abort in RUN cycle 5: busy low the next cycle, no done, lap_cnt unchanged.
REQ-035 SHALL cover clamping and error detection: chain_len=0, W=0 -> L=2, W=1, lap_cnt=0; a forced second token in RUN -> token_err=1.
REQ-036 SHALL cover rst_n asserted mid-RUN: all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/t_clkq_ring_meter.sv
// Token-ring clock meter: circulates a single token around an L-stage DFF ring
// for W cycles and reports how many full laps it completed.
module t_clkq_ring_meter #(
  parameter int N         = 16,
  parameter int CNT_WIDTH = 8,
  parameter int WIN_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [$clog2(N+1)-1:0] chain_len,
  input  logic [WIN_WIDTH-1:0]   win_len,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   lap_cnt,
  output logic                   overflow,
  output logic                   token_err
);

  localparam int LW = $clog2(N+1);
  localparam logic [LW-1:0]        L_MIN   = LW'(2);
  localparam logic [LW-1:0]        L_MAX   = LW'(N);
  localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state_q;
  logic [LW-1:0]        len_q, len_d;
  logic [WIN_WIDTH-1:0] win_q, win_d;
  logic [N-1:0]         ring_q, ring_d, live, occ;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, lap_q;
  logic                 busy_q, done_q, ovf_q, err_q;
  logic                 tail, sat, ovf_hit, one_hot;

  assign busy      = busy_q;
  assign done      = done_q;
  assign lap_cnt   = lap_q;
  assign overflow  = ovf_q;
  assign token_err = err_q;

  always_comb begin
    len_d = chain_len;
    if (chain_len < L_MIN)      len_d = L_MIN;
    else if (chain_len > L_MAX) len_d = L_MAX;
    win_d = (win_len == '0) ? WIN_ONE : win_len;
  end

  // live marks the active stages; tail is stage L-1, found without a variable index
  always_comb begin
    live = '0;
    tail = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (LW'(i) < len_q)       live[i] = 1'b1;
      if (LW'(i + 1) == len_q)  tail    = ring_q[i];
    end
    ring_d      = '0;
    ring_d[N-1:1] = ring_q[N-2:0] & live[N-1:1];
    ring_d[0]   = tail;
    occ         = ring_q & live;
    one_hot     = (occ != '0) && ((occ & (occ - N'(1))) == '0);
    sat         = &cnt_q;
    ovf_hit     = tail & sat;
    cnt_d       = (tail && !sat) ? cnt_q + CNT_ONE : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      win_q   <= '0;
      ring_q  <= '0;
      cnt_q   <= '0;
      lap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            len_q   <= len_d;
            win_q   <= win_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ring_q  <= N'(1);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ring_q <= ring_d;
            cnt_q  <= cnt_d;
            if (ovf_hit)  ovf_q <= 1'b1;
            if (!one_hot) err_q <= 1'b1;
            // lap_q takes cnt_d so the last RUN cycle's lap is included
            if (win_q == WIN_ONE) begin
              lap_q   <= cnt_d;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              win_q <= win_q - WIN_ONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
